seq_lowerer_select_fifo: RTL and testbench

//  Registered stage downstream of the combinational case/select logic: captures the

---
 rtl/seq_lowerer_select_fifo_if.sv | 30 +++
 rtl/seq_lowerer_select_fifo.sv | 129 ++++++++++++
 tb/tb_seq_lowerer_select_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seq_lowerer_select_fifo_if.sv
// Handshake bundle for seq_lowerer_select_fifo: the upstream select/operand side and the downstream FIFO head.
// The master modport is the environment; the slave modport is the FIFO stage.
interface seq_lowerer_select_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, sel, a, b, c, flush, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, sel, a, b, c, flush, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/seq_lowerer_select_fifo.sv
// Registered select stage: the operand picked by sel is pushed into a circular FIFO drained by a flush FSM.
// Optional zero-latency bypass when empty is enabled by defining SEQ_LOWERER_BYPASS_EN.
module seq_lowerer_select_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seq_lowerer_select_fifo_if.slave      bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sel_data;
  logic             in_ready, out_valid, bypass, push, pop;
  logic [AW-1:0]    dbg_free_slot, scan_idx;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_data = bus.a;
    case (bus.sel)
      2'b00, 2'b01: sel_data = bus.a;
      2'b10:        sel_data = bus.b;
      default:      sel_data = bus.c;
    endcase
  end

  // Handshake and occupancy; a bypassed word is neither stored nor popped.
  always_comb begin
    in_ready = (state != DRAIN) && !bus.flush && ((count < CW'(DEPTH)) || bus.out_ready);
`ifdef SEQ_LOWERER_BYPASS_EN
    bypass = (state == EMPTY) && (count == '0) && bus.in_valid && bus.out_ready && in_ready;
`else
    bypass = 1'b0;
`endif
    out_valid = (count != '0) || bypass;
    push      = bus.in_valid && in_ready && !bypass;
    pop       = (count != '0) && bus.out_ready;
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (bus.flush)       state_nxt = DRAIN;
        else if (push)       state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.flush)                    state_nxt = DRAIN;
        else if (count_nxt == CW'(DEPTH)) state_nxt = FULL;
        else if (count_nxt == '0)         state_nxt = EMPTY;
      end
      FULL: begin
        if (bus.flush)       state_nxt = DRAIN;
        else if (pop && !push) state_nxt = BUSY;
      end
      default: begin
        if (count == '0)     state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Clear happens before set so a full push+pop on the same slot leaves it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (pop) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr] <= sel_data;
        wr_ptr      <= ptr_inc(wr_ptr);
        vld[wr_ptr] <= 1'b1;
      end
    end
  end

  // Debug scan from the head for the first unoccupied slot; when full it falls back to rd_ptr.
  always_comb begin
    dbg_free_slot = rd_ptr;
    scan_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + AW'(k);
      if (!vld[scan_idx]) begin
        dbg_free_slot = scan_idx;
        break;
      end
    end
  end

  free_slot_matches_wr_ptr: assert property (@(posedge clk) disable iff (!rst_n) dbg_free_slot == wr_ptr);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count;
  assign bus.out_data  = bypass ? sel_data : ((count != '0) ? mem[rd_ptr] : '0);

endmodule

// File: tb/tb_seq_lowerer_select_fifo.sv
// Directed bench for seq_lowerer_select_fifo: reset, select, fill/drain, wrap, flush, mid-cycle reset, bypass.
// Expected values follow SEQ_LOWERER_BYPASS_EN when it is defined for the build.
module tb_seq_lowerer_select_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount  = 0;

  logic [7:0] t2exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t3exp [6] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
  logic [7:0] t4exp [3] = '{8'h63, 8'h64, 8'h65};

  seq_lowerer_select_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  seq_lowerer_select_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] s, input logic [7:0] av,
                               input logic [7:0] bv, input logic [7:0] cv,
                               input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.a         = av;
    bus.b         = bv;
    bus.c         = cv;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while held
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_count",     32'(bus.count),     32'd0);
    checkOutput("rst_out_data",  32'(bus.out_data),  32'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checkOutput("rel_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rel_count",    32'(bus.count),    32'd0);

    // Fill through every select code with out_ready low
    applyStimulus(1'b1, 2'b00, 8'h11, 8'hEE, 8'hEE, 1'b0, 1'b0);
    #1;
    checkOutput("t2_in_ready_empty", 32'(bus.in_ready), 32'd1);
    step();
    checkOutput("t2_latency_data", 32'(bus.out_data), 32'h11);
    checkOutput("t2_count1",       32'(bus.count),    32'd1);
    applyStimulus(1'b1, 2'b10, 8'hEE, 8'h22, 8'hEE, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b11, 8'hEE, 8'hEE, 8'h33, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 8'h44, 8'hEE, 8'hEE, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b00, 8'h99, 8'h99, 8'h99, 1'b0, 1'b0);
    #1;
    checkOutput("t2_count_full",    32'(bus.count),    32'd4);
    checkOutput("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("t2_no_push_full",  32'(bus.count),    32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("t2_drain%0d", i), 32'(bus.out_data), 32'(t2exp[i]));
      step();
    end
    checkOutput("t2_count_empty",     32'(bus.count),     32'd0);
    checkOutput("t2_out_valid_empty", 32'(bus.out_valid), 32'd0);

    // Full with push+pop each cycle across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b10, 8'h00, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0);
      step();
    end
    checkOutput("t3_refill_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'(8'h60 + i), 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("t3_in_ready%0d", i), 32'(bus.in_ready), 32'd1);
      checkOutput($sformatf("t3_data%0d", i),     32'(bus.out_data), 32'(t3exp[i]));
      step();
      checkOutput($sformatf("t3_count%0d", i),    32'(bus.count),    32'd4);
    end

    // Flush from count=3; pushes blocked while draining
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    #1;
    checkOutput("t4_pop_data", 32'(bus.out_data), 32'h62);
    step();
    checkOutput("t4_count3", 32'(bus.count), 32'd3);
    applyStimulus(1'b1, 2'b00, 8'hAB, 8'h00, 8'h00, 1'b0, 1'b1);
    #1;
    checkOutput("t4_in_ready_flush", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("t4_count_after_flush", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'b00, 8'hAB, 8'h00, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("t4_in_ready_drain%0d", i), 32'(bus.in_ready), 32'd0);
      checkOutput($sformatf("t4_drain_data%0d", i),     32'(bus.out_data), 32'(t4exp[i]));
      step();
    end
    checkOutput("t4_count_zero",     32'(bus.count),    32'd0);
    checkOutput("t4_still_draining", 32'(bus.in_ready), 32'd0);
    step();
    checkOutput("t4_in_ready_empty", 32'(bus.in_ready), 32'd1);
    checkOutput("t4_count_empty",    32'(bus.count),    32'd0);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset pulse between edges with two entries held
    applyStimulus(1'b1, 2'b00, 8'h71, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b10, 8'h00, 8'h72, 8'h00, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t5_count2", 32'(bus.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_rst_count",     32'(bus.count),     32'd0);
    checkOutput("t5_rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("t5_rst_out_data",  32'(bus.out_data),  32'h00);
    #1;
    rst_n = 1'b1;
    step();
    checkOutput("t5_post_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_post_out_data",  32'(bus.out_data),  32'h00);
    applyStimulus(1'b1, 2'b11, 8'h00, 8'h00, 8'h7E, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t5_fresh_data",  32'(bus.out_data), 32'h7E);
    checkOutput("t5_fresh_count", 32'(bus.count),    32'd1);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t5_final_count", 32'(bus.count), 32'd0);

    // Empty FIFO with both sides ready
    applyStimulus(1'b1, 2'b10, 8'h11, 8'h5A, 8'h33, 1'b1, 1'b0);
    #1;
`ifdef SEQ_LOWERER_BYPASS_EN
    checkOutput("t6_bypass_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t6_bypass_data",  32'(bus.out_data),  32'h5A);
    checkOutput("t6_bypass_count", 32'(bus.count),     32'd0);
    step();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t6_after_count", 32'(bus.count),     32'd0);
    checkOutput("t6_after_valid", 32'(bus.out_valid), 32'd0);
`else
    checkOutput("t6_same_cycle_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_same_cycle_data",  32'(bus.out_data),  32'h00);
    step();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t6_next_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t6_next_data",  32'(bus.out_data),  32'h5A);
    checkOutput("t6_next_count", 32'(bus.count),     32'd1);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    checkOutput("t6_final_count", 32'(bus.count), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
